// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: FSM encoding,
// fetch-buffer entry layout and PC helpers.
package fetch_unit_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    REQ  = ST_REQ,
    WAIT = ST_WAIT,
    HOLD = ST_HOLD
  } fetch_state_e;

  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Redirect targets are word aligned; low two bits are ignored.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Registered fetch buffer feeding IF/ID plus a one-entry skid that absorbs a
// response arriving while the buffer is full and stalled.
module fetch_skid_buf
  import fetch_unit_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         fill,
  input  fetch_entry_t fill_data,
  input  logic         consume,
  input  logic         kill,
  output logic         valid,
  output logic [31:0]  pc,
  output logic [31:0]  instr,
  output logic         skid_full
);

  fetch_entry_t buf_r;
  fetch_entry_t skid_r;
  logic         valid_r;
  logic         skid_full_r;

  // Buffer/skid update; kill wins over everything, then fill, then draining the skid.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      buf_r       <= '{pc: 32'h0000_0000, instr: NOP};
      skid_r      <= '{pc: 32'h0000_0000, instr: NOP};
      valid_r     <= 1'b0;
      skid_full_r <= 1'b0;
    end else if (kill) begin
      buf_r.instr <= NOP;
      valid_r     <= 1'b0;
      skid_full_r <= 1'b0;
    end else if (fill && (!valid_r || consume)) begin
      buf_r   <= fill_data;
      valid_r <= 1'b1;
    end else if (fill) begin
      skid_r      <= fill_data;
      skid_full_r <= 1'b1;
    end else if (consume && skid_full_r) begin
      buf_r       <= skid_r;
      valid_r     <= 1'b1;
      skid_full_r <= 1'b0;
    end else if (consume) begin
      // PC is left as-is so IF/ID still sees the last fetched address.
      buf_r.instr <= NOP;
      valid_r     <= 1'b0;
    end
  end

  assign valid     = valid_r;
  assign pc        = buf_r.pc;
  assign instr     = buf_r.instr;
  assign skid_full = skid_full_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, single-outstanding imem request FSM, branch
// redirect with wrong-path response kill, and the IF/ID-facing fetch buffer.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        Stall_i,
  input  logic        Branch_i,
  input  logic [31:0] BranchTarget_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] PC_o,
  output logic [31:0] instr_o,
  output logic        valid_o,
  output logic        Flush_o
);

  fetch_state_e state_r, state_s;
  logic [31:0]  pc_r, pc_s;
  logic [31:0]  req_pc_r, req_pc_s;
  logic         drop_r, drop_s;
  logic         req_r, req_s;
  logic [31:0]  addr_r, addr_s;
  logic         fill_s;
  logic         buf_valid_s;
  logic         skid_full_s;
  logic [31:0]  target_s;
  fetch_entry_t fill_data_s;

  assign target_s    = align_word(BranchTarget_i);
  assign fill_data_s = '{pc: req_pc_r, instr: imem_rdata_i};

  // Next-state, next-PC and drop-flag logic; a redirect overrides stall and fill.
  always_comb begin
    state_s  = state_r;
    pc_s     = pc_r;
    req_pc_s = req_pc_r;
    drop_s   = drop_r;
    fill_s   = 1'b0;
    case (state_r)
      IDLE: begin
        state_s = REQ;
        if (Branch_i) pc_s = target_s;
        else          pc_s = pc_r;
      end
      REQ: begin
        if (imem_gnt_i) begin
          state_s  = WAIT;
          req_pc_s = pc_r;
          // A redirect on the grant edge makes this request wrong-path.
          drop_s   = Branch_i;
        end else begin
          state_s = REQ;
        end
        if (Branch_i) pc_s = target_s;
        else          pc_s = pc_r;
      end
      WAIT: begin
        if (Branch_i) begin
          pc_s = target_s;
          if (imem_rvalid_i) begin
            state_s = REQ;
            drop_s  = 1'b0;
          end else begin
            drop_s  = 1'b1;
          end
        end else if (imem_rvalid_i) begin
          if (drop_r) begin
            drop_s  = 1'b0;
            state_s = REQ;
          end else begin
            pc_s   = req_pc_r + 32'd4;
            fill_s = 1'b1;
            if (!buf_valid_s || !Stall_i) state_s = REQ;
            else                          state_s = HOLD;
          end
        end else begin
          state_s = WAIT;
        end
      end
      HOLD: begin
        if (Branch_i) begin
          pc_s    = target_s;
          state_s = REQ;
        end else if (!Stall_i) begin
          state_s = REQ;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    req_s = (state_s == REQ);
    if (req_s) addr_s = pc_s;
    else       addr_s = 32'h0000_0000;
  end

  // FSM, PC and request-port registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r  <= IDLE;
      pc_r     <= RESET_PC;
      req_pc_r <= 32'h0000_0000;
      drop_r   <= 1'b0;
      req_r    <= 1'b0;
      addr_r   <= 32'h0000_0000;
    end else begin
      state_r  <= state_s;
      pc_r     <= pc_s;
      req_pc_r <= req_pc_s;
      drop_r   <= drop_s;
      req_r    <= req_s;
      addr_r   <= addr_s;
    end
  end

  fetch_skid_buf u_skid_buf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .fill      (fill_s),
    .fill_data (fill_data_s),
    .consume   (!Stall_i),
    .kill      (Branch_i),
    .valid     (buf_valid_s),
    .pc        (PC_o),
    .instr     (instr_o),
    .skid_full (skid_full_s)
  );

  assign valid_o     = buf_valid_s;
  assign imem_req_o  = req_r;
  assign imem_addr_o = addr_r;
  assign Flush_o     = Branch_i;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: latency-programmable memory responder, queue-based
// reference model with a per-cycle scoreboard, and directed scenarios.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] XMASK  = 32'hA5A5_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        Stall_i, Branch_i;
  logic [31:0] BranchTarget_i;
  logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
  logic [31:0] imem_addr_o, imem_rdata_i;
  logic [31:0] PC_o, instr_o;
  logic        valid_o, Flush_o;

  logic gnt_en  = 1'b1;
  int   rsp_lat = 1;
  int   n_checks = 0;
  int   n_fail   = 0;

  // reference model state
  logic        m_started = 1'b0, m_out = 1'b0, m_drop = 1'b0, m_valid = 1'b0;
  logic [31:0] m_pc = RST_PC, m_reqpc = 32'h0, m_pcout = 32'h0, m_instr = NOP;
  logic [63:0] m_skid[$];

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .Stall_i(Stall_i), .Branch_i(Branch_i),
    .BranchTarget_i(BranchTarget_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .PC_o(PC_o), .instr_o(instr_o), .valid_o(valid_o), .Flush_o(Flush_o)
  );

  always #5 clk_i = ~clk_i;
  assign imem_gnt_i = imem_req_o & gnt_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %08h required %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic at_pos();
    @(posedge clk_i); #1;
  endtask

  task automatic at_neg();
    @(negedge clk_i); #2;
  endtask

  // memory: response rsp_lat cycles after grant, data = addr ^ XMASK
  initial begin : mem_model
    int cnt;
    logic [31:0] paddr;
    cnt = 0; paddr = 32'h0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    forever begin
      @(negedge clk_i); #1;
      imem_rvalid_i = 1'b0;
      if (!rst_i) cnt = 0;
      else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = paddr ^ XMASK;
        end
      end
      #2;
      if (rst_i && imem_req_o && gnt_en) begin
        paddr = imem_addr_o;
        cnt   = rsp_lat;
      end
    end
  end

  // scoreboard: step the model on every edge and compare all outputs
  initial begin : scoreboard
    logic s_st, s_br, s_gnt, s_rv, req_now, exp_req, filled;
    logic [31:0] s_tgt, s_rd;
    logic [63:0] e;
    forever begin
      @(negedge clk_i); #4;
      s_st = Stall_i; s_br = Branch_i; s_tgt = BranchTarget_i;
      s_rv = imem_rvalid_i; s_rd = imem_rdata_i;
      req_now = m_started && !m_out && (m_skid.size() == 0);
      s_gnt = gnt_en && req_now;
      if (rst_i) chk("flush_copy", {31'h0, Flush_o}, {31'h0, s_br});
      @(posedge clk_i); #1;
      filled = 1'b0;
      if (!rst_i) begin
        m_started = 1'b0; m_out = 1'b0; m_drop = 1'b0; m_valid = 1'b0;
        m_pc = RST_PC; m_pcout = 32'h0; m_instr = NOP; m_skid.delete();
      end else if (s_br) begin
        m_pc = s_tgt & 32'hFFFF_FFFC;
        m_valid = 1'b0; m_instr = NOP; m_skid.delete();
        if (!m_started) m_started = 1'b1;
        else if (req_now && s_gnt) begin m_out = 1'b1; m_drop = 1'b1; end
        else if (m_out && !s_rv) m_drop = 1'b1;
        else if (m_out && s_rv) begin m_out = 1'b0; m_drop = 1'b0; end
      end else begin
        if (!m_started) m_started = 1'b1;
        else if (req_now && s_gnt) begin m_out = 1'b1; m_reqpc = m_pc; end
        else if (m_out && s_rv) begin
          m_out = 1'b0;
          if (m_drop) m_drop = 1'b0;
          else begin
            m_pc = m_reqpc + 32'd4;
            if (!m_valid || !s_st) begin
              m_valid = 1'b1; m_pcout = m_reqpc; m_instr = s_rd; filled = 1'b1;
            end else m_skid.push_back({m_reqpc, s_rd});
          end
        end else if (m_skid.size() != 0 && !s_st) begin
          e = m_skid.pop_front();
          m_pcout = e[63:32]; m_instr = e[31:0]; m_valid = 1'b1; filled = 1'b1;
        end
        if (!s_st && !filled) begin m_valid = 1'b0; m_instr = NOP; end
      end
      exp_req = m_started && !m_out && (m_skid.size() == 0);
      chk("sb_pc", PC_o, m_pcout);
      chk("sb_instr", instr_o, m_instr);
      chk("sb_valid", {31'h0, valid_o}, {31'h0, m_valid});
      chk("sb_req", {31'h0, imem_req_o}, {31'h0, exp_req});
      if (exp_req) chk("sb_addr", imem_addr_o, m_pc);
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete, actual timeout required finish");
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] reqs[$];
    logic [31:0] ins[$];
    int vcnt;
    vcnt = 0;
    Stall_i = 1'b0; Branch_i = 1'b0; BranchTarget_i = 32'h0;
    rst_i = 1'b1;
    #1 rst_i = 1'b0;
    at_neg();
    chk("rst_pc", PC_o, 32'h0);
    chk("rst_instr", instr_o, NOP);
    chk("rst_valid", {31'h0, valid_o}, 32'h0);
    chk("rst_req", {31'h0, imem_req_o}, 32'h0);
    chk("rst_addr", imem_addr_o, 32'h0);
    at_neg();
    rst_i = 1'b1;

    // zero-wait streaming from RESET_PC
    for (int i = 0; i < 8; i++) begin
      at_pos();
      if (imem_req_o) reqs.push_back(imem_addr_o);
      if (valid_o) begin vcnt++; ins.push_back(instr_o); end
    end
    chk("s1_nreq", 32'(reqs.size()), 32'd4);
    chk("s1_req0", reqs[0], 32'h0000_0100);
    chk("s1_req1", reqs[1], 32'h0000_0104);
    chk("s1_req2", reqs[2], 32'h0000_0108);
    chk("s1_nvalid", 32'(vcnt), 32'd3);
    chk("s1_ins0", ins[0], 32'hA5A5_0100);
    chk("s1_ins1", ins[1], 32'hA5A5_0104);
    chk("s1_ins2", ins[2], 32'hA5A5_0108);

    // stall for 5 edges; second response lands in the skid
    at_neg(); Stall_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      at_pos();
      chk("s2_pc_frozen", PC_o, 32'h0000_010C);
      chk("s2_instr_frozen", instr_o, 32'hA5A5_010C);
      chk("s2_valid", {31'h0, valid_o}, 32'h1);
      if (i > 0) chk("s2_noreq", {31'h0, imem_req_o}, 32'h0);
    end
    at_neg(); Stall_i = 1'b0;
    at_pos();
    chk("s2_skid_pc", PC_o, 32'h0000_0110);
    chk("s2_skid_instr", instr_o, 32'hA5A5_0110);
    chk("s2_resume_req", {31'h0, imem_req_o}, 32'h1);
    chk("s2_resume_addr", imem_addr_o, 32'h0000_0114);
    at_pos(); at_pos();
    chk("s2_next_pc", PC_o, 32'h0000_0114);

    // redirect in WAIT, stale response 3 cycles later
    at_neg(); rsp_lat = 3;
    at_pos();
    chk("s3_wait_noreq", {31'h0, imem_req_o}, 32'h0);
    at_neg(); Branch_i = 1'b1; BranchTarget_i = 32'h0000_0200;
    #1 chk("s3_flush_hi", {31'h0, Flush_o}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      at_pos();
      chk("s3_no_stale", instr_o, NOP);
      chk("s3_invalid", {31'h0, valid_o}, 32'h0);
      if (i == 0) begin
        at_neg(); Branch_i = 1'b0; rsp_lat = 1;
        #1 chk("s3_flush_lo", {31'h0, Flush_o}, 32'h0);
      end
    end
    chk("s3_redirect_req", {31'h0, imem_req_o}, 32'h1);
    chk("s3_redirect_addr", imem_addr_o, 32'h0000_0200);
    at_pos(); at_pos();
    chk("s3_target_instr", instr_o, 32'hA5A5_0200);

    // branch coincident with rvalid while stalled
    at_neg(); Stall_i = 1'b1;
    at_pos();
    chk("s4_held_pc", PC_o, 32'h0000_0200);
    at_neg(); Branch_i = 1'b1; BranchTarget_i = 32'h0000_0203;
    at_pos();
    chk("s4_killed_instr", instr_o, NOP);
    chk("s4_killed_valid", {31'h0, valid_o}, 32'h0);
    chk("s4_req", {31'h0, imem_req_o}, 32'h1);
    chk("s4_aligned_addr", imem_addr_o, 32'h0000_0200);
    at_neg(); Branch_i = 1'b0; Stall_i = 1'b0;
    at_pos(); at_pos();
    chk("s4_refetch", instr_o, 32'hA5A5_0200);

    // redirect on a grant edge to the last word; PC wraps to 0
    at_neg(); Branch_i = 1'b1; BranchTarget_i = 32'hFFFF_FFFC;
    at_pos();
    chk("s5_drop_noreq", {31'h0, imem_req_o}, 32'h0);
    at_neg(); Branch_i = 1'b0;
    at_pos();
    chk("s5_req_top", imem_addr_o, 32'hFFFF_FFFC);
    at_pos(); at_pos();
    chk("s5_top_pc", PC_o, 32'hFFFF_FFFC);
    chk("s5_top_instr", instr_o, 32'h5A5A_FFFC);
    chk("s5_wrap_addr", imem_addr_o, 32'h0000_0000);

    // asynchronous reset mid-WAIT
    at_neg(); rsp_lat = 3;
    at_pos();
    chk("s6_in_wait", {31'h0, imem_req_o}, 32'h0);
    at_neg(); rst_i = 1'b0;
    #1;
    chk("s6_rst_pc", PC_o, 32'h0);
    chk("s6_rst_instr", instr_o, NOP);
    chk("s6_rst_valid", {31'h0, valid_o}, 32'h0);
    chk("s6_rst_req", {31'h0, imem_req_o}, 32'h0);
    chk("s6_rst_addr", imem_addr_o, 32'h0);
    at_neg(); at_neg(); rst_i = 1'b1; rsp_lat = 1;
    at_pos();
    chk("s6_first_req", imem_addr_o, RST_PC);
    at_pos(); at_pos();
    chk("s6_first_instr", instr_o, 32'hA5A5_0100);

    at_pos();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage front end. Holds the PC and issues single-outstanding requests to instruction memory over a request/grant + response-valid handshake. Returns fetched words through a registered fetch buffer that drives the IF/ID pipeline register's `PC_i`/`instr_i` inputs. Honours the hazard unit's stall, and the branch redirect from ID, including killing an in-flight wrong-path response.

## Interface
- `RESET_PC`, 32'h0000_0000, PC of first fetch after reset
- `NOP`, 32'h0000_0000, instruction word presented when no valid fetch is available
- `clk_i` in 1: single clock, rising edge
- `rst_i` in 1: asynchronous, active-low reset
- `Stall_i` in 1: IF/ID stall from hazard unit; fetch buffer must hold
- `Branch_i` in 1: taken-branch redirect from ID
- `BranchTarget_i` in 32: redirect PC; bits [1:0] forced to 0
- `imem_req_o` out 1: memory request valid
- `imem_addr_o` out 32: request address
- `imem_gnt_i` in 1: request accepted this cycle
- `imem_rvalid_i` in 1: response valid
- `imem_rdata_i` in 32: response instruction
- `PC_o` out 32: to IF/ID `PC_i`
- `instr_o` out 32: to IF/ID `instr_i`
- `valid_o` out 1: fetch buffer holds a real instruction
- `Flush_o` out 1: to IF/ID `Flush_i`; combinational copy of `Branch_i`

## Operation
- Reset values:
  - `pc_q`=RESET_PC, state=IDLE, `imem_req_o`=0, `imem_addr_o`=0.
  - `PC_o`=0, `instr_o`=NOP, `valid_o`=0.
  - Skid empty, drop flag 0.
- **IDLE**: go to REQ on the first edge after reset release.
- **REQ**: `imem_req_o`=1, `imem_addr_o`=`pc_q`.
  - On `imem_gnt_i`: capture `req_pc`=`pc_q`, go to WAIT.
  - Address may change before grant; a redirect updates `pc_q` in place.
- **WAIT**: `imem_req_o`=0. On `imem_rvalid_i`:
  - If drop=1: discard the response, clear drop, go to REQ.
  - Else if buffer is empty or being consumed (`Stall_i`=0): buffer←{`req_pc`, `imem_rdata_i`}, `valid_o`=1, `pc_q`←`req_pc`+4, go to REQ.
  - Else (buffer full and `Stall_i`=1): skid←{`req_pc`, rdata}, `pc_q`←`req_pc`+4, go to HOLD.
- **HOLD**: no requests. On the first cycle with `Stall_i`=0: buffer←skid, skid empty, go to REQ.
- Buffer consumption: on any edge with `Stall_i`=0 and no new fill, `valid_o`←0, `instr_o`←NOP, `PC_o` holds.
- `Branch_i`=1 has priority over `Stall_i` and over any fill:
  - `pc_q`←target, buffer invalidated (`instr_o`←NOP, `valid_o`←0), skid emptied.
  - REQ: stay in REQ with the new address. If grant occurs in the same cycle, go to WAIT with drop=1.
  - WAIT without rvalid: set drop=1.
  - WAIT with rvalid in the same cycle: discard that response, go to REQ.
  - HOLD: go to REQ.
- PC arithmetic: 32-bit, +4 wraps modulo 2^32 (32'hFFFF_FFFC → 0).

## Timing
- Zero-wait memory (grant in the request cycle, rvalid the next cycle): 2 cycles per instruction. The response appears on `PC_o`/`instr_o` one edge after `imem_rvalid_i`.
- Redirect latency: `Branch_i` at edge N; a request to the target is driven in cycle N+1 at the latest. With drop pending, the request is driven the cycle after the stale rvalid.
- At most one outstanding request; `imem_req_o` is never asserted in WAIT or HOLD.
- `Flush_o` has zero latency, so IF/ID zeroes the wrong-path word latched at the branch edge.
- Asynchronous reset mid-WAIT clears drop and state. The memory must not return a response after reset; the bench enforces this.

## Structure
- Shared package holds:
  - state encoding localparams: IDLE, REQ, WAIT, HOLD
  - `NOP` constant
  - default `RESET_PC`
- One sub-module, `fetch_skid_buf`: the output buffer plus the one-entry skid. Ports: fill, fill data, consume (`!Stall_i`), kill (`Branch_i`), `valid`, `PC`, `instr`, `skid_full`.
- FSM, `pc_q`, `req_pc` and drop flag live in `fetch_unit`.

## Test plan
- Reset with RESET_PC=32'h100, zero-wait memory returning addr^32'hA5A5_0000, then release. Required: requests to 0x100, 0x104, 0x108; `instr_o` sequence 0xA5A5_0100, 0xA5A5_0104, …; `valid_o` toggles 1/0.
- Hold `Stall_i`=1 for 5 cycles while a response arrives with the buffer full. Required: `PC_o`/`instr_o` frozen, state HOLD, no `imem_req_o`. On release, the skid word appears next cycle, then fetch resumes at +4.
- `Branch_i` with target 32'h200 while in WAIT, with rvalid 3 cycles later. Required: the stale word never reaches `instr_o`, `Flush_o`=1 for that cycle, next request address is 0x200.
- `Branch_i` and `imem_rvalid_i` in the same cycle, with `Stall_i`=1 also asserted. Required: response discarded, buffer NOP/`valid_o`=0, request to target next cycle.
- `pc_q`=32'hFFFF_FFFC fetched. Required: next request address 32'h0. Target 32'h203 produces request address 32'h200.
- Assert `rst_i` low mid-WAIT. Required: all outputs return to reset values immediately (asynchronous reset), and the first request after release is to RESET_PC.
